// File: rtl/toggle_decoder.sv
// Receive-side toggle decoder: synchronises a toggle-encoded level, filters it for stability
// and turns each accepted level change into an event held until the consumer acknowledges it.
module toggle_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tog_in,
  input  logic             en,
  input  logic             evt_ack,
  input  logic             clr_ovr,
  output logic             evt_valid,
  output logic             evt_level,
  output logic [CNT_W-1:0] evt_count,
  output logic             overrun,
  output logic             tog_state,
  output logic [1:0]       dbg_state
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    ACCEPT  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s;
  logic [STAB_W-1:0]       stab_cnt;
  logic [STAB_W-1:0]       stab_cnt_nxt;
  logic                    accept;
  logic                    ref_load;

  assign s         = sync_q[SYNC_STAGES-1];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_cnt_nxt;
    end
  end

  // stab_cnt counts how many consecutive samples the synced level has differed from tog_state.
  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = stab_cnt;
    if (!en) begin
      state_nxt    = IDLE;
      stab_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s != tog_state) begin
            state_nxt    = CONFIRM;
            stab_cnt_nxt = STAB_W'(1);
          end
        end
        CONFIRM: begin
          if (s == tog_state) begin
            state_nxt    = IDLE;
            stab_cnt_nxt = '0;
          end else if (stab_cnt < STAB_W'(STABLE_CYCLES)) begin
            stab_cnt_nxt = stab_cnt + STAB_W'(1);
          end else begin
            state_nxt = ACCEPT;
          end
        end
        ACCEPT: begin
          state_nxt    = IDLE;
          stab_cnt_nxt = '0;
        end
        default: begin
          state_nxt    = IDLE;
          stab_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept   = en && (state == ACCEPT);
    ref_load = !en || accept;
  end

  // Handshake: evt_valid rises on an accepted event and stays high until a cycle with
  // evt_ack=1 while evt_valid=1; an accept in that same cycle keeps it high for the new event.
  // An accept while an unacked event is still pending sets the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q    <= '0;
      tog_state <= 1'b0;
      evt_valid <= 1'b0;
      evt_level <= 1'b0;
      evt_count <= '0;
      overrun   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      if (ref_load) begin
        tog_state <= s;
      end
      if (accept) begin
        evt_level <= s;
        evt_count <= evt_count + CNT_W'(1);
        evt_valid <= 1'b1;
      end else if (evt_ack) begin
        evt_valid <= 1'b0;
      end
      if (accept && evt_valid && !evt_ack) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// Bench for toggle_decoder: directed scenarios plus random toggling, checked against a
// cycle-level reference model with an event scoreboard drained by an independent monitor.
module tb_toggle_decoder;

  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int CW   = 8;
  localparam int EW   = 16 + 1 + CW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tog_in;
  logic          en;
  logic          evt_ack;
  logic          clr_ovr;
  logic          evt_valid;
  logic          evt_level;
  logic [CW-1:0] evt_count;
  logic          overrun;
  logic          tog_state;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  toggle_decoder #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .tog_in(tog_in), .en(en), .evt_ack(evt_ack),
    .clr_ovr(clr_ovr), .evt_valid(evt_valid), .evt_level(evt_level), .evt_count(evt_count),
    .overrun(overrun), .tog_state(tog_state), .dbg_state(dbg_state)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: sampled tog_in history, filtered level and handshake outputs.
  logic          hist[$];
  logic          m_ref, m_valid, m_level, m_ovr, m_rst;
  logic [CW-1:0] m_count;
  int            run;
  bit            acc;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic s;
    bit   fire;
    bit   set_ovr;
    cyc++;
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      m_ref = 0; m_valid = 0; m_level = 0; m_ovr = 0; m_count = '0;
      run = 0; acc = 0; m_rst = 1;
      exp_q.delete();
      return;
    end
    m_rst = 0;
    s = hist.pop_front();
    hist.push_back(tog_in);
    fire = 0;
    if (!en) begin
      m_ref = s; run = 0; acc = 0;
    end else if (acc) begin
      fire = 1; acc = 0; run = 0; m_ref = s;
    end else if (s != m_ref) begin
      run++;
      // A change must be seen on STAB+1 consecutive samples; it is taken on the next edge.
      if (run == STAB + 1) begin
        acc = 1; run = 0;
      end
    end else begin
      run = 0;
    end
    set_ovr = fire && m_valid && !evt_ack;
    if (fire) begin
      m_valid = 1; m_level = s; m_count = m_count + 1'b1;
    end else if (m_valid && evt_ack) begin
      m_valid = 0;
    end
    if (set_ovr) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
    if (fire) exp_q.push_back({cyc[15:0], m_level, m_count, m_ovr});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0; tog_in = 0; evt_ack = 0; clr_ovr = 0;
    repeat (2) step();
    reset_n = 1;
  endtask

  // Monitor: per-cycle output compare plus scoreboard pop whenever a new event appears.
  initial begin : monitor
    logic [CW-1:0] prev_cnt;
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    prev_cnt = '0;
    forever begin
      @(negedge clk);
      if (cyc == 0) continue;
      if (m_rst) begin
        check("rst_valid", int'(evt_valid), 0);
        check("rst_level", int'(evt_level), 0);
        check("rst_count", int'(evt_count), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_tog_state", int'(tog_state), 0);
        check("rst_fsm", int'(dbg_state), 0);
        prev_cnt = '0;
      end else begin
        check("valid", int'(evt_valid), int'(m_valid));
        check("overrun", int'(overrun), int'(m_ovr));
        check("tog_state", int'(tog_state), int'(m_ref));
        if (evt_count != prev_cnt) begin
          obs = {cyc[15:0], evt_level, evt_count, overrun};
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL event_unexpected: got count %0d level %0d, none expected (cycle %0d)",
                     evt_count, evt_level, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event", int'(obs), int'(e));
          end
          prev_cnt = evt_count;
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++; n_err++;
          $display("FAIL event_missed: got count %0d, expected count %0d level %0d (cycle %0d)",
                   evt_count, e[CW:1], e[CW+1], cyc);
        end
      end
    end
  end

  initial begin : stimulus
    int c0;
    logic [CW-1:0] saved;
    int hold;
    reset_n = 0; tog_in = 0; en = 1; evt_ack = 0; clr_ovr = 0;

    // 1: single event, exact latency, ack clears valid
    do_reset();
    step();
    check("t1_idle_valid", int'(evt_valid), 0);
    tog_in = 1;
    step();
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      step();
      if (evt_valid) break;
    end
    check("t1_latency", cyc - c0, 7);
    check("t1_level", int'(evt_level), 1);
    check("t1_count", int'(evt_count), 1);
    check("t1_tog_state", int'(tog_state), 1);
    evt_ack = 1; step(); evt_ack = 0;
    check("t1_ack_clears", int'(evt_valid), 0);

    // 2: 3-cycle glitch is filtered
    do_reset();
    tog_in = 1; repeat (3) step();
    tog_in = 0; repeat (10) step();
    check("t2_no_valid", int'(evt_valid), 0);
    check("t2_count", int'(evt_count), 0);
    check("t2_tog_state", int'(tog_state), 0);

    // 3: two events without ack -> overrun, then clear
    tog_in = 1; repeat (10) step();
    tog_in = 0; repeat (10) step();
    check("t3_overrun", int'(overrun), 1);
    check("t3_level", int'(evt_level), 0);
    check("t3_count", int'(evt_count), 2);
    check("t3_valid", int'(evt_valid), 1);
    clr_ovr = 1; step(); clr_ovr = 0;
    check("t3_clr_ovr", int'(overrun), 0);

    // 4: ack on the same edge as the next accept
    evt_ack = 1; step(); evt_ack = 0;
    tog_in = 1; repeat (10) step();
    check("t4_first_valid", int'(evt_valid), 1);
    tog_in = 0; step();
    repeat (6) step();
    evt_ack = 1; step(); evt_ack = 0;
    check("t4_valid_kept", int'(evt_valid), 1);
    check("t4_no_overrun", int'(overrun), 0);
    check("t4_level", int'(evt_level), 0);
    check("t4_count", int'(evt_count), 4);

    // 5: en=0 tracks silently; then 256 events wrap the counter
    evt_ack = 1; step(); evt_ack = 0;
    saved = evt_count;
    en = 0;
    tog_in = 1; repeat (3) step();
    tog_in = 0; repeat (3) step();
    tog_in = 1; repeat (10) step();
    check("t5_track", int'(tog_state), 1);
    en = 1; repeat (10) step();
    check("t5_no_event", int'(evt_count), int'(saved));
    check("t5_no_valid", int'(evt_valid), 0);
    do_reset();
    for (int k = 0; k < 256; k++) begin
      tog_in = ~tog_in;
      for (int j = 0; j < 8; j++) begin
        evt_ack = 1'($urandom_range(0, 1));
        step();
      end
    end
    evt_ack = 0; repeat (10) step();
    check("t5_wrap", int'(evt_count), 0);

    // 6: reset mid-CONFIRM and with an event pending
    do_reset();
    tog_in = 1; repeat (4) step();
    reset_n = 0; tog_in = 0; step(); reset_n = 1;
    check("t6_fsm_cleared", int'(dbg_state), 0);
    repeat (10) step();
    check("t6_no_stale_count", int'(evt_count), 0);
    check("t6_no_stale_valid", int'(evt_valid), 0);
    tog_in = 1; repeat (10) step();
    check("t6_pending", int'(evt_valid), 1);
    reset_n = 0; tog_in = 0; step(); reset_n = 1;
    check("t6_valid_cleared", int'(evt_valid), 0);
    check("t6_level_cleared", int'(evt_level), 0);
    repeat (10) step();
    check("t6_still_clear", int'(evt_count), 0);

    // Random phase
    for (int seg = 0; seg < 250; seg++) begin
      tog_in = ~tog_in;
      en = ($urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : $urandom_range(6, 14);
      for (int j = 0; j < hold; j++) begin
        evt_ack = ($urandom_range(0, 3) == 0);
        clr_ovr = ($urandom_range(0, 19) == 0);
        reset_n = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    reset_n = 1; en = 1; evt_ack = 0; clr_ovr = 0;
    repeat (12) step();
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
